// File: rtl/cpu_pkg.sv
// cpu_pkg: shared align_load bit indices and writeback queue depth legality check
package cpu_pkg;
  localparam int AL_LW  = 6;
  localparam int AL_LB  = 5;
  localparam int AL_LBU = 4;
  localparam int AL_LH  = 3;
  localparam int AL_LHU = 2;
  localparam int AL_LWL = 1;
  localparam int AL_LWR = 0;
  function automatic bit depth_ok(int d);
    return d == 2 || d == 4 || d == 8;
  endfunction
endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: extracts load result from the data word; lwl/lwr merging only when WB_QUEUE_LWLR_EN is defined
module wb_load_align
  import cpu_pkg::*;
(
  input  logic [31:0] data,
  input  logic [31:0] rf_b,
  input  logic [1:0]  off,
  input  logic [6:0]  align_load,
  output logic [31:0] res
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] lwlr;
  assign b = 8'(data >> {off, 3'b000});
  assign h = off[1] ? data[31:16] : data[15:0];
`ifdef WB_QUEUE_LWLR_EN
  // lwl fills the top bytes from the low data bytes, lwr fills the low bytes from the high data bytes
  always_comb begin
    lwlr = '0;
    if (align_load[AL_LWL])
      lwlr = (data << {~off, 3'b000}) | (rf_b & ~(32'hFFFF_FFFF << {~off, 3'b000}));
    else if (align_load[AL_LWR])
      lwlr = (data >> {off, 3'b000}) | (rf_b & ~(32'hFFFF_FFFF >> {off, 3'b000}));
  end
`else
  logic unused_rf_b;
  assign unused_rf_b = ^rf_b;
  assign lwlr = '0;
`endif
  assign res = align_load[AL_LW]  ? data :
               align_load[AL_LB]  ? {{24{b[7]}}, b} :
               align_load[AL_LBU] ? {24'b0, b} :
               align_load[AL_LH]  ? {{16{h[15]}}, h} :
               align_load[AL_LHU] ? {16'b0, h} : lwlr;
endmodule

// File: rtl/wb_queue.sv
// wb_queue: in-order writeback FIFO that waits for in-order load data before retiring; WB_QUEUE_LWLR_EN enables lwl/lwr merging
module wb_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_p,
  input  logic                       MA_valid,
  output logic                       WB_enable,
  input  logic [31:0]                rf_B_in,
  input  logic [4:0]                 rf_waddr_in,
  input  logic                       rf_wen_in,
  input  logic [31:0]                alu_res_in,
  input  logic                       mem_read_in,
  input  logic [6:0]                 align_load_in,
  input  logic [31:0]                MA_PC,
  input  logic                       interlayer_ready,
  input  logic [31:0]                mem_data,
  output logic                       rf_wen_leaving,
  output logic [4:0]                 rf_waddr_out,
  output logic [31:0]                rf_wdata_out,
  output logic [31:0]                debug_PC,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_waddr,
  output logic [31:0]                debug_wb_rf_wdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       data_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  if (!depth_ok(DEPTH)) begin : g_depth_chk
    $error("wb_queue: DEPTH must be 2, 4 or 8");
  end
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      alu_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [4:0]       waddr_q[DEPTH];
  logic [6:0]       al_q   [DEPTH];
  logic [DEPTH-1:0] wen_q, rd_q, vld_q, ok_q;
  logic [PW-1:0]    head, tail, ld_ptr;
  logic             ld_hit, retire, enq, beat;
  logic [31:0]      head_rfb, aligned;
  assign retire    = vld_q[head] && ok_q[head];
  assign WB_enable = (count < CW'(DEPTH)) || retire;
  assign enq       = MA_valid && WB_enable;
  assign beat      = interlayer_ready;
  // load pointer: oldest valid entry still waiting for its data beat, searched from the head
  always_comb begin
    ld_ptr = head;
    ld_hit = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (vld_q[head + PW'(i)] && !ok_q[head + PW'(i)]) begin
        ld_ptr = head + PW'(i);
        ld_hit = 1'b1;
      end
  end
  // queue control: pointers, occupancy, per-entry flags and the sticky stray-beat error
  always_ff @(posedge clk) begin
    if (rst_p) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      vld_q    <= '0;
      ok_q     <= '0;
      data_err <= 1'b0;
    end else begin
      if (retire) begin
        vld_q[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (beat && ld_hit) ok_q[ld_ptr] <= 1'b1;
      if (beat && !ld_hit) data_err <= 1'b1;
      if (enq) begin
        vld_q[tail] <= 1'b1;
        ok_q[tail]  <= !mem_read_in;
        tail        <= tail + 1'b1;
      end
      count <= count + CW'(enq) - CW'(retire);
    end
  end
  // entry payload and load data storage; contents are only meaningful while the entry is valid
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_q[tail]    <= MA_PC;
      alu_q[tail]   <= alu_res_in;
      waddr_q[tail] <= rf_waddr_in;
      al_q[tail]    <= align_load_in;
      wen_q[tail]   <= rf_wen_in;
      rd_q[tail]    <= mem_read_in;
    end
    if (beat && ld_hit) data_q[ld_ptr] <= mem_data;
  end
`ifdef WB_QUEUE_LWLR_EN
  logic [31:0] rfb_q [DEPTH];
  // rf_B is only kept for the lwl/lwr merge
  always_ff @(posedge clk) begin
    if (enq) rfb_q[tail] <= rf_B_in;
  end
  assign head_rfb = rfb_q[head];
`else
  logic unused_rf_b;
  assign unused_rf_b = ^rf_B_in;
  assign head_rfb    = '0;
`endif
  wb_load_align u_align (
    .data      (data_q[head]),
    .rf_b      (head_rfb),
    .off       (alu_q[head][1:0]),
    .align_load(al_q[head]),
    .res       (aligned)
  );
  assign rf_wen_leaving    = retire && wen_q[head];
  assign rf_waddr_out      = waddr_q[head];
  assign rf_wdata_out      = rd_q[head] ? aligned : alu_q[head];
  assign debug_PC          = pc_q[head];
  assign debug_wb_rf_wen   = {4{rf_wen_leaving}};
  assign debug_wb_rf_waddr = rf_waddr_out;
  assign debug_wb_rf_wdata = rf_wdata_out;
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: randomized and directed checks of wb_queue against a queue-based reference model
module tb_wb_queue;
  localparam int DEPTH = 4;
  logic        clk = 0, rst_p = 1, MA_valid = 0, WB_enable;
  logic [31:0] rf_B_in = 0, alu_res_in = 0, MA_PC = 0, mem_data = 0;
  logic [4:0]  rf_waddr_in = 0;
  logic        rf_wen_in = 0, mem_read_in = 0, interlayer_ready = 0;
  logic [6:0]  align_load_in = 0;
  logic        rf_wen_leaving, data_err;
  logic [4:0]  rf_waddr_out, debug_wb_rf_waddr;
  logic [31:0] rf_wdata_out, debug_PC, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [2:0]  count;
  int n_chk = 0, n_fail = 0;

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_p(rst_p), .MA_valid(MA_valid), .WB_enable(WB_enable),
    .rf_B_in(rf_B_in), .rf_waddr_in(rf_waddr_in), .rf_wen_in(rf_wen_in),
    .alu_res_in(alu_res_in), .mem_read_in(mem_read_in), .align_load_in(align_load_in),
    .MA_PC(MA_PC), .interlayer_ready(interlayer_ready), .mem_data(mem_data),
    .rf_wen_leaving(rf_wen_leaving), .rf_waddr_out(rf_waddr_out), .rf_wdata_out(rf_wdata_out),
    .debug_PC(debug_PC), .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_waddr(debug_wb_rf_waddr),
    .debug_wb_rf_wdata(debug_wb_rf_wdata), .count(count), .data_err(data_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, alu, rfb, data;
    logic [4:0]  waddr;
    logic [6:0]  al;
    bit          wen, rd, ok;
  } ent_t;
  ent_t q[$];
  bit   m_err = 0, mdl_on = 0;

  function automatic logic [31:0] byte_of(logic [31:0] w, int j);
    return {24'b0, w[8*j +: 8]};
  endfunction

  // expected write data derived byte by byte from the load-type rules
  function automatic logic [31:0] exp_wd(ent_t e);
    int k = int'(e.alu[1:0]);
    logic [31:0] r = 0;
    logic [7:0] by = e.data[8*k +: 8];
    logic [15:0] hw = e.alu[1] ? e.data[31:16] : e.data[15:0];
    if (!e.rd) return e.alu;
    if (e.al[6]) return e.data;
    if (e.al[5]) return by[7] ? 32'hFFFFFF00 + {24'b0, by} : {24'b0, by};
    if (e.al[4]) return {24'b0, by};
    if (e.al[3]) return hw[15] ? 32'hFFFF0000 + {16'b0, hw} : {16'b0, hw};
    if (e.al[2]) return {16'b0, hw};
`ifdef WB_QUEUE_LWLR_EN
    if (e.al[1]) begin
      for (int j = 0; j < 4; j++)
        r[8*j +: 8] = (j >= 3 - k) ? byte_of(e.data, j - (3 - k))[7:0] : byte_of(e.rfb, j)[7:0];
      return r;
    end
    if (e.al[0]) begin
      for (int j = 0; j < 4; j++)
        r[8*j +: 8] = (j <= 3 - k) ? byte_of(e.data, j + k)[7:0] : byte_of(e.rfb, j)[7:0];
      return r;
    end
`endif
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: retire, beat fill, enqueue evaluated on the pre-edge contents
  always @(posedge clk) begin : model
    bit r, hit;
    ent_t e;
    if (rst_p) begin
      q.delete();
      m_err  = 0;
      mdl_on = 1;
    end else if (mdl_on) begin
      r = q.size() > 0 && q[0].ok;
      if (interlayer_ready) begin
        hit = 0;
        for (int i = 0; i < q.size(); i++)
          if (!q[i].ok) begin
            e = q[i]; e.data = mem_data; e.ok = 1; q[i] = e; hit = 1;
            break;
          end
        if (!hit) m_err = 1;
      end
      if (r) void'(q.pop_front());
      if (MA_valid && (q.size() + (r ? 1 : 0) < DEPTH || r)) begin
        e.pc = MA_PC; e.alu = alu_res_in; e.rfb = rf_B_in; e.data = 0;
        e.waddr = rf_waddr_in; e.al = align_load_in; e.wen = rf_wen_in;
        e.rd = mem_read_in; e.ok = !mem_read_in;
        q.push_back(e);
      end
    end
  end

  // compare every cycle away from the active edge
  always @(negedge clk) begin : compare
    bit r;
    if (mdl_on && !rst_p) begin
      r = q.size() > 0 && q[0].ok;
      chk("count", 32'(count), q.size());
      chk("wb_enable", 32'(WB_enable), 32'(q.size() < DEPTH || r));
      chk("rf_wen_leaving", 32'(rf_wen_leaving), 32'(r && q[0].wen));
      chk("debug_wb_rf_wen", 32'(debug_wb_rf_wen), (r && q[0].wen) ? 32'hF : 32'h0);
      chk("data_err", 32'(data_err), 32'(m_err));
      if (r) begin
        chk("rf_wdata_out", rf_wdata_out, exp_wd(q[0]));
        chk("rf_waddr_out", 32'(rf_waddr_out), 32'(q[0].waddr));
        chk("debug_PC", debug_PC, q[0].pc);
        chk("debug_wdata", debug_wb_rf_wdata, exp_wd(q[0]));
        chk("debug_waddr", 32'(debug_wb_rf_waddr), 32'(q[0].waddr));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    MA_valid = 0; interlayer_ready = 0; rst_p = 0;
  endtask

  task automatic enq(logic [31:0] pc, logic [31:0] alu, logic [4:0] wa, bit rd, logic [6:0] al, logic [31:0] rfb);
    MA_valid = 1; MA_PC = pc; alu_res_in = alu; rf_waddr_in = wa; rf_wen_in = 1;
    mem_read_in = rd; align_load_in = al; rf_B_in = rfb;
  endtask

  task automatic beat(logic [31:0] d);
    interlayer_ready = 1; mem_data = d;
  endtask

  task automatic load_then_beat(logic [6:0] al, logic [31:0] alu, logic [31:0] rfb, logic [31:0] d, logic [31:0] exp, string nm);
    enq(32'h200, alu, 5'd9, 1, al, rfb); cyc();
    chk({nm, "_wait"}, 32'(rf_wen_leaving), 0);
    beat(d); cyc();
    chk({nm, "_wen"}, 32'(rf_wen_leaving), 1);
    chk(nm, rf_wdata_out, exp);
    cyc();
  endtask

  initial begin
    rst_p = 1; cyc(); rst_p = 1; cyc();
    chk("reset_count", 32'(count), 0);
    chk("reset_wb_enable", 32'(WB_enable), 1);
    chk("reset_wen_leaving", 32'(rf_wen_leaving), 0);
    chk("reset_data_err", 32'(data_err), 0);
    enq(32'h100, 32'h12345678, 5'd5, 0, 7'h00, 0); cyc();
    chk("nonload_wen", 32'(rf_wen_leaving), 1);
    chk("nonload_wdata", rf_wdata_out, 32'h12345678);
    chk("nonload_waddr", 32'(rf_waddr_out), 5);
    cyc();
    chk("nonload_count0", 32'(count), 0);
    load_then_beat(7'b0100000, 32'h1003, 0, 32'h80FF0011, 32'hFFFFFF80, "lb_off3");
    load_then_beat(7'b0010000, 32'h1003, 0, 32'h80FF0011, 32'h00000080, "lbu_off3");
    load_then_beat(7'b0100000, 32'h1002, 0, 32'h80FF0011, 32'hFFFFFFFF, "lb_off2");
    load_then_beat(7'b0001000, 32'h1002, 0, 32'h80FF0011, 32'hFFFF80FF, "lh_hi");
    load_then_beat(7'b0000100, 32'h1000, 0, 32'h80FF8011, 32'h00008011, "lhu_lo");
`ifdef WB_QUEUE_LWLR_EN
    load_then_beat(7'b0000010, 32'h1001, 32'h11223344, 32'hAABBCCDD, 32'hCCDD3344, "lwl_k1");
    load_then_beat(7'b0000001, 32'h1002, 32'h11223344, 32'hAABBCCDD, 32'h1122AABB, "lwr_k2");
`else
    load_then_beat(7'b0000010, 32'h1001, 32'h11223344, 32'hAABBCCDD, 32'h00000000, "lwl_off");
`endif
    for (int i = 0; i < 4; i++) begin enq(32'h300 + i, 32'h40 + 4 * i, 5'(i + 1), 1, 7'b1000000, 0); cyc(); end
    chk("full_wb_enable", 32'(WB_enable), 0);
    chk("full_count", 32'(count), 4);
    for (int i = 0; i < 4; i++) begin
      beat(32'hA0000000 + i); cyc();
      chk("drain_wdata", rf_wdata_out, 32'hA0000000 + i);
      chk("drain_waddr", 32'(rf_waddr_out), i + 1);
    end
    cyc();
    chk("drain_count0", 32'(count), 0);
    for (int i = 0; i < 4; i++) begin enq(32'h400 + i, 32'h80, 5'(i + 1), 1, 7'b1000000, 0); cyc(); end
    beat(32'h5555AAAA); cyc();
    chk("full_ready_wb_enable", 32'(WB_enable), 1);
    enq(32'h500, 32'hCAFE, 5'd7, 0, 0, 0); cyc();
    chk("full_enq_retire_count", 32'(count), 4);
    rst_p = 1; cyc();
    interlayer_ready = 1; mem_data = 32'h1; cyc();
    chk("stray_beat_err", 32'(data_err), 1);
    chk("stray_beat_nowrite", 32'(rf_wen_leaving), 0);
    for (int i = 0; i < 3; i++) begin enq(32'h600, 32'h0, 5'd3, 1, 7'b1000000, 0); cyc(); end
    chk("three_count", 32'(count), 3);
    rst_p = 1; cyc();
    chk("midreset_count", 32'(count), 0);
    chk("midreset_err", 32'(data_err), 0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 1) == 1)
        enq($urandom, $urandom, 5'($urandom), $urandom_range(0, 1) == 1, 7'(1) << $urandom_range(0, 6), $urandom);
      rf_wen_in = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 2) == 0) beat($urandom);
      if ($urandom_range(0, 199) == 0) rst_p = 1;
      cyc();
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
